// File: rtl/clkmon_pkg.sv
// ============================================================================
//  Module   : clkmon_pkg
//  Purpose  : Shared types and constants for the clock-edge monitor: the
//             monitor state encoding, the period/counter width and the
//             default synchronizer depth and loss timeout.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package clkmon_pkg;

    // Width of the cycle counter and of the reported period.
    localparam int unsigned c_period_w = 32;

    // Defaults: two synchronizer flops, one second of silence at 50 MHz.
    localparam int unsigned                c_default_sync_stages = 2;
    localparam logic [c_period_w-1:0]      c_default_timeout     = 32'd50000000;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sync_edge.sv
// ============================================================================
//  Module   : sync_edge
//  Purpose  : Brings the asynchronous sclk into the iclk domain through a
//             SYNC_STAGES-deep flop chain plus one history flop, and emits
//             registered one-cycle rise/fall pulses.
//  Ports    : iclk       - system clock
//             reset      - synchronous active-high reset
//             sclk       - asynchronous slow clock / level input
//             rise_pulse - one iclk cycle per synchronized rising edge
//             fall_pulse - one iclk cycle per synchronized falling edge
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_edge
    import clkmon_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = c_default_sync_stages  // >= 2
) (
    input  logic iclk,
    input  logic reset,
    input  logic sclk,
    output logic rise_pulse,
    output logic fall_pulse
);

    logic [SYNC_STAGES-1:0] r_sync;
    // Marks which synchronizer stages hold a real sample of sclk rather
    // than the reset value.
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_hist;
    // Rising edges are only reported once a genuine low level has been
    // seen since reset; a sclk already high at reset release would
    // otherwise look like a rising edge against the cleared flops.
    logic                   r_armed;

    logic w_level;
    logic w_level_real;

    assign w_level      = r_sync[SYNC_STAGES-1];
    assign w_level_real = r_fill[SYNC_STAGES-1];

    always_ff @(posedge iclk) begin
        if (reset) begin
            r_sync     <= '0;
            r_fill     <= '0;
            r_hist     <= 1'b0;
            r_armed    <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], sclk};
            r_fill     <= {r_fill[SYNC_STAGES-2:0], 1'b1};
            r_hist     <= w_level;
            r_armed    <= r_armed | (w_level_real & ~w_level);
            rise_pulse <= w_level & ~r_hist & r_armed;
            fall_pulse <= ~w_level & r_hist;
        end
    end

endmodule

`default_nettype wire

// File: rtl/clkedge_monitor.sv
// ============================================================================
//  Module   : clkedge_monitor
//  Purpose  : Measures the period of a slow asynchronous clock in iclk
//             cycles, tracks whether it is present (LOCKED) or has gone
//             silent for TIMEOUT cycles (LOST).
//  Ports    : iclk         - system clock (only clock of the block)
//             reset        - synchronous active-high reset
//             sclk         - asynchronous slow clock / level input
//             rise_pulse   - one-cycle pulse per synchronized sclk rise
//             fall_pulse   - one-cycle pulse per synchronized sclk fall
//             period       - iclk cycles between the last two rises
//             period_valid - one-cycle pulse when period is updated
//             locked       - high while in LOCKED
//             lost         - high while in LOST
//  Options  : CLKMON_STABILITY_EN - when defined, locking needs two equal
//             consecutive periods and any period change drops back to
//             MEASURE.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module clkedge_monitor
    import clkmon_pkg::*;
#(
    parameter int unsigned            SYNC_STAGES = c_default_sync_stages, // >= 2
    parameter logic [c_period_w-1:0]  TIMEOUT     = c_default_timeout      // >= 2
) (
    input  logic                  iclk,
    input  logic                  reset,
    input  logic                  sclk,
    output logic                  rise_pulse,
    output logic                  fall_pulse,
    output logic [c_period_w-1:0] period,
    output logic                  period_valid,
    output logic                  locked,
    output logic                  lost
);

    localparam logic [c_period_w-1:0] c_timeout_last = TIMEOUT - c_period_w'(1);

    state_t                r_state;
    logic [c_period_w-1:0] r_count;
    logic [c_period_w-1:0] w_count_inc;
    logic                  w_timeout;
`ifdef CLKMON_STABILITY_EN
    // Set once period holds a measurement usable as the lock reference.
    logic                  r_have_ref;
`endif

    sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .iclk       (iclk),
        .reset      (reset),
        .sclk       (sclk),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    // Saturating increment; also the period measured when a rise lands
    // this cycle (count restarts at 0 the cycle after a rise).
    assign w_count_inc = (r_count == '1) ? r_count : r_count + c_period_w'(1);
    assign w_timeout   = (r_count == c_timeout_last);

    // State, counter, period and the locked/lost decodes all live here so
    // locked/lost are registered alongside the state they describe.
    always_ff @(posedge iclk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            lost         <= 1'b0;
`ifdef CLKMON_STABILITY_EN
            r_have_ref   <= 1'b0;
`endif
        end else begin
            period_valid <= 1'b0;
            r_count      <= rise_pulse ? '0 : w_count_inc;

            case (r_state)
                ST_IDLE: begin
                    if (rise_pulse) begin
                        r_state <= ST_MEASURE;
`ifdef CLKMON_STABILITY_EN
                        r_have_ref <= 1'b0;
`endif
                    end
                end

                ST_MEASURE: begin
                    // A rise always beats a coincident timeout.
                    if (rise_pulse) begin
                        period       <= w_count_inc;
                        period_valid <= 1'b1;
`ifdef CLKMON_STABILITY_EN
                        if (r_have_ref && (w_count_inc == period)) begin
                            r_state <= ST_LOCKED;
                            locked  <= 1'b1;
                        end else begin
                            r_have_ref <= 1'b1;
                        end
`else
                        r_state <= ST_LOCKED;
                        locked  <= 1'b1;
`endif
                    end else if (w_timeout) begin
                        r_state <= ST_LOST;
                        lost    <= 1'b1;
                    end
                end

                ST_LOCKED: begin
                    if (rise_pulse) begin
                        period       <= w_count_inc;
                        period_valid <= 1'b1;
`ifdef CLKMON_STABILITY_EN
                        // The differing period becomes the new reference.
                        if (w_count_inc != period) begin
                            r_state    <= ST_MEASURE;
                            locked     <= 1'b0;
                            r_have_ref <= 1'b1;
                        end
`endif
                    end else if (w_timeout) begin
                        r_state <= ST_LOST;
                        locked  <= 1'b0;
                        lost    <= 1'b1;
                    end
                end

                ST_LOST: begin
                    // Period keeps the last good value; the interval that
                    // ends here spans the outage and is not meaningful.
                    if (rise_pulse) begin
                        r_state <= ST_MEASURE;
                        lost    <= 1'b0;
`ifdef CLKMON_STABILITY_EN
                        r_have_ref <= 1'b0;
`endif
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    locked  <= 1'b0;
                    lost    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clkedge_monitor.sv
// ============================================================================
//  Module   : tb_clkedge_monitor
//  Purpose  : Self-checking bench for clkedge_monitor (SYNC_STAGES=2,
//             TIMEOUT=20): edge latency, period measurement and locking,
//             loss timeout, recovery, rise-vs-timeout priority and reset.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clkedge_monitor;

    logic        iclk  = 1'b0;
    logic        reset = 1'b1;
    logic        sclk  = 1'b0;
    logic        rise_pulse;
    logic        fall_pulse;
    logic [31:0] period;
    logic        period_valid;
    logic        locked;
    logic        lost;

    int errors = 0;
    int checks = 0;

    // Observations accumulated by run_seg.
    int seg_rises;
    int seg_pvs;
    int seg_lost;

    typedef struct {
        int          half;
        int          reps;
        int          rises;
        int          pvs;
        logic [31:0] per;
        logic        lck;
    } vec_t;

    vec_t tbl [6];

    clkedge_monitor #(
        .SYNC_STAGES (2),
        .TIMEOUT     (32'd20)
    ) dut (
        .iclk         (iclk),
        .reset        (reset),
        .sclk         (sclk),
        .rise_pulse   (rise_pulse),
        .fall_pulse   (fall_pulse),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .lost         (lost)
    );

    always #5 iclk = ~iclk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic observe();
        if (rise_pulse)   seg_rises++;
        if (period_valid) seg_pvs++;
        if (lost)         seg_lost = 1;
    endtask

    // Drive reps full sclk periods, each high for h cycles then low for h.
    task automatic run_seg(input int h, input int reps);
        seg_rises = 0;
        seg_pvs   = 0;
        seg_lost  = 0;
        for (int r = 0; r < reps; r++) begin
            sclk = 1'b1;
            for (int i = 0; i < h; i++) begin tick(); observe(); end
            sclk = 1'b0;
            for (int i = 0; i < h; i++) begin tick(); observe(); end
        end
    endtask

    initial begin
        int found;
        int lost_seen;

        // Each segment's first rise measures the distance back to the
        // previous segment's rise, so a new half-period shows up only on
        // the second rise of the segment.
        tbl[0] = '{half: 4, reps: 1, rises: 1, pvs: 1, per: 32'd8,  lck: 1'b1};
        tbl[1] = '{half: 4, reps: 1, rises: 1, pvs: 1, per: 32'd8,  lck: 1'b1};
        tbl[2] = '{half: 5, reps: 2, rises: 2, pvs: 2, per: 32'd10, lck: 1'b1};
        tbl[3] = '{half: 5, reps: 1, rises: 1, pvs: 1, per: 32'd10, lck: 1'b1};
        tbl[4] = '{half: 6, reps: 2, rises: 2, pvs: 2, per: 32'd12, lck: 1'b1};
        tbl[5] = '{half: 6, reps: 1, rises: 1, pvs: 1, per: 32'd12, lck: 1'b1};
`ifdef CLKMON_STABILITY_EN
        tbl[0].lck = 1'b0;   // only one 8 so far
        tbl[2].lck = 1'b0;   // 8 then 10: change drops lock
        tbl[4].lck = 1'b0;   // 10 then 12: change drops lock
`endif

        // ---- reset state ----
        reset = 1'b1;
        sclk  = 1'b0;
        repeat (3) tick();
        check("reset_rise",   rise_pulse,   0);
        check("reset_fall",   fall_pulse,   0);
        check("reset_period", period,       0);
        check("reset_pv",     period_valid, 0);
        check("reset_locked", locked,       0);
        check("reset_lost",   lost,         0);

        reset = 1'b0;
        repeat (4) tick();

        // ---- edge latency: rise visible on the 3rd edge after sclk rises ----
        sclk = 1'b1;
        tick(); check("lat_rise_e1", rise_pulse, 0);
        tick(); check("lat_rise_e2", rise_pulse, 0);
        tick(); check("lat_rise_e3", rise_pulse, 1);
        check("idle_locked", locked, 0);
        tick(); check("lat_rise_e4", rise_pulse, 0);
        check("idle_no_pv",  period_valid, 0);
        check("idle_period", period,       0);
        sclk = 1'b0;
        tick(); check("lat_fall_e1", fall_pulse, 0);
        tick(); check("lat_fall_e2", fall_pulse, 0);
        tick(); check("lat_fall_e3", fall_pulse, 1);
        tick(); check("lat_fall_e4", fall_pulse, 0);

        // ---- table-driven period / lock segments ----
        for (int v = 0; v < 6; v++) begin
            run_seg(tbl[v].half, tbl[v].reps);
            check($sformatf("tbl%0d_rises",  v), seg_rises, tbl[v].rises);
            check($sformatf("tbl%0d_pvs",    v), seg_pvs,   tbl[v].pvs);
            check($sformatf("tbl%0d_period", v), period,    tbl[v].per);
            check($sformatf("tbl%0d_locked", v), locked,    tbl[v].lck);
            check($sformatf("tbl%0d_lost",   v), seg_lost,  0);
        end

        // ---- loss timeout: one more rise, then sclk held low ----
        sclk  = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (rise_pulse) found = 1;
        end
        check("to_rise_seen", found, 1);
        sclk      = 1'b0;
        lost_seen = 0;
        // Counter runs 0..19 over the 20 cycles after the rise cycle;
        // lost appears on the following edge.
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (lost) lost_seen++;
        end
        check("to_lost_early",  lost_seen, 0);
        check("to_locked_pre",  locked,    1);
        tick();
        check("to_lost",        lost,      1);
        check("to_locked",      locked,    0);
        check("to_period_held", period,    12);

        // ---- recovery from LOST at a 12-cycle period ----
        run_seg(6, 1);
        check("rec1_rises",  seg_rises, 1);
        check("rec1_pvs",    seg_pvs,   0);
        check("rec1_period", period,    12);
        check("rec1_lost",   lost,      0);
        check("rec1_locked", locked,    0);
        run_seg(6, 1);
        check("rec2_pvs",    seg_pvs,   1);
        check("rec2_period", period,    12);
`ifdef CLKMON_STABILITY_EN
        check("rec2_locked", locked,    0);
`else
        check("rec2_locked", locked,    1);
`endif
        run_seg(6, 1);
        check("rec3_locked", locked,    1);

        // ---- rise coinciding with counter == TIMEOUT-1 ----
        run_seg(10, 1);
        check("edge_pre_period", period, 12);
        sclk      = 1'b1;
        found     = 0;
        lost_seen = seg_lost;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (lost) lost_seen++;
            if (rise_pulse) found = 1;
        end
        check("edge_rise_seen", found, 1);
        tick();
        if (lost) lost_seen++;
        check("edge_pv",     period_valid, 1);
        check("edge_period", period,       20);
        tick();
        if (lost) lost_seen++;
        check("edge_no_lost", lost_seen, 0);
`ifdef CLKMON_STABILITY_EN
        check("edge_locked", locked, 0);
`else
        check("edge_locked", locked, 1);
`endif

        // ---- reset with sclk high ----
        tick();
        reset = 1'b1;
        tick();
        check("mid_rst_rise",   rise_pulse,   0);
        check("mid_rst_fall",   fall_pulse,   0);
        check("mid_rst_period", period,       0);
        check("mid_rst_pv",     period_valid, 0);
        check("mid_rst_locked", locked,       0);
        check("mid_rst_lost",   lost,         0);
        reset = 1'b0;
        found = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (rise_pulse) found++;
        end
        check("post_rst_no_rise", found, 0);
        sclk = 1'b0;
        repeat (4) tick();
        sclk = 1'b1;
        tick();
        tick(); check("post_rst_rise_e2", rise_pulse, 0);
        tick(); check("post_rst_rise_e3", rise_pulse, 1);
        check("post_rst_period", period, 0);
        check("post_rst_locked", locked, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clkedge_monitor.md
CLKEDGE_MONITOR -- requirements
Module: clkedge_monitor

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on sclk (minimum 2).
REQ-002 Parameter TIMEOUT, default 32'd50000000, iclk cycles without a rising sclk edge before loss is declared (minimum 2).
REQ-003 Port iclk  input  1  system clock (50 MHz); the block's only clock.
REQ-004 Port reset  input  1  synchronous, active-high reset, sampled on posedge iclk.
REQ-005 Port sclk  input  1  slow clock or level signal, asynchronous to iclk (e.g. a divided clock).
REQ-006 Port rise_pulse  output  1  one-cycle pulse per synchronized rising edge of sclk.
REQ-007 Port fall_pulse  output  1  one-cycle pulse per synchronized falling edge of sclk.
REQ-008 Port period  output  32  iclk cycles between the last two rise_pulse assertions.
REQ-009 Port period_valid  output  1  one-cycle pulse when period is updated.
REQ-010 Port locked  output  1  high while state is LOCKED.
REQ-011 Port lost  output  1  high while state is LOST.

Function
REQ-012 The block SHALL pass sclk through SYNC_STAGES flops, then one history flop; rise_pulse = sync & ~hist, fall_pulse = ~sync & hist, both registered.
REQ-013 Latency: rise_pulse/fall_pulse SHALL assert SYNC_STAGES+1 iclk edges after the first edge sampling the new sclk level; high exactly one cycle.
REQ-014 A 32-bit cycle counter SHALL load 0 in a rise_pulse cycle, else increment, saturating at 32'hFFFFFFFF.
REQ-015 In a rise_pulse cycle outside IDLE, the block SHALL load period <= counter+1 and pulse period_valid; sclk toggling every 4 iclk gives period = 8.
REQ-016 FSM states IDLE, MEASURE, LOCKED, LOST, held in an enumerated type.
REQ-017 IDLE: on rise_pulse -> MEASURE; period unchanged.
REQ-018 MEASURE: on rise_pulse -> LOCKED (subject to REQ-024); on counter == TIMEOUT-1 with no rise_pulse -> LOST.
REQ-019 LOCKED: each rise_pulse updates period and stays LOCKED; counter == TIMEOUT-1 with no rise_pulse -> LOST.
REQ-020 LOST: on rise_pulse -> MEASURE, counter restarts at 0; period holds last value and is not updated on that edge.
REQ-021 If rise_pulse and the timeout condition coincide, rise_pulse SHALL win (no transition to LOST).
REQ-022 locked and lost SHALL be registered decodes of state, never both high.

Reset
REQ-023 With reset high at a posedge iclk: state=IDLE, all sync/history flops=0, counter=0, period=0, rise_pulse=fall_pulse=period_valid=locked=lost=0; reset mid-operation discards any partial measurement and a rising edge of sclk already high at release is not reported until sclk falls and rises again.

Configuration
REQ-024 Macro CLKMON_STABILITY_EN: when defined, MEASURE->LOCKED SHALL require two consecutive measured periods exactly equal (a mismatch stays in MEASURE and replaces the reference period), and LOCKED SHALL go to MEASURE on any period differing from the previous one; when undefined, the first measured period locks and period changes never unlock.

Structure
REQ-025 Package clkmon_pkg SHALL hold the state enum typedef, the 32-bit period width constant and default TIMEOUT/SYNC_STAGES constants.
REQ-026 Sub-module sync_edge SHALL implement the synchronizer, history flop and rise/fall pulse generation (REQ-012/013); clkedge_monitor instantiates it once.

Verification
REQ-027 sclk toggles every 4 iclk from reset release -> first rise_pulse SYNC_STAGES+1 cycles after sclk rise; period=8 with period_valid on 2nd rise; locked=1 after 2nd rise (3rd with CLKMON_STABILITY_EN).
REQ-028 TIMEOUT=20, sclk held low after lock -> lost=1 exactly 20 cycles after last rise_pulse, locked=0, period still 8.
REQ-029 From LOST, resume sclk every 6 iclk -> MEASURE on first rise (period unchanged), period=12 and locked on next rise.
REQ-030 Rise arranged on the cycle where counter==TIMEOUT-1 -> stays LOCKED, period=TIMEOUT, lost never asserts.
REQ-031 Reset asserted while LOCKED with sclk high -> all outputs 0 next cycle; no rise_pulse after release until sclk falls and rises.
REQ-032 With CLKMON_STABILITY_EN, periods 8,10,10 -> locked only after the second 10; subsequent 12 -> locked drops, state MEASURE.
